// File: rtl/player_ctrl.sv
// rtl/player_ctrl.sv - music player control: button debounce, mode FSM, song/pause tracking, output muxing
// Optional feature macro: PLAYER_CTRL_AUTONEXT_EN (song_end advances the song instead of pausing)
module player_ctrl #(
  parameter int NUM_SONGS  = 4,
  parameter int SONG_W     = 2,
  parameter int DEB_CYCLES = 2000000,
  parameter int LED_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        button,
  input  logic [2:0]        mode,
  input  logic              song_end,
  input  logic              speaker_auto,
  input  logic              speaker_key,
  input  logic              speaker_study,
  input  logic [LED_W-1:0]  led_auto,
  input  logic [LED_W-1:0]  led_study,
  output logic [SONG_W-1:0] song_num,
  output logic              pause,
  output logic              song_chg,
  output logic [1:0]        state,
  output logic              speaker,
  output logic [LED_W-1:0]  led
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [SONG_W-1:0] SONG_MAX = SONG_W'(NUM_SONGS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_AUTO   = 2'd1,
    S_MANUAL = 2'd2,
    S_STUDY  = 2'd3
  } state_t;

  logic [2:0]       sync1_q, sync2_q;
  logic [1:0]       vld_q;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [2:0]       deb_q, deb_d, deb_dly_q;
  logic [2:0]       arm_q, arm_d;
  logic [2:0]       pulse;
  logic             prev_p, pause_p, next_p;

  state_t            state_q, state_d;
  logic [SONG_W-1:0] song_num_q, song_num_d, song_last_q;
  logic              pause_q, pause_d;
  logic              song_chg_q;
  logic              speaker_q, speaker_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic              play, auto_run, step_up, end_pause;

  // Two-flop synchroniser; vld_q marks when sync2_q holds a real post-reset sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      vld_q   <= '0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[0], 1'b1};
    end
  end

  // Per-bit debounce counter; a button is armed only once it is seen released after reset
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
      arm_d[i] = arm_q[i] | (vld_q[1] & ~sync2_q[i]);
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      arm_q     <= '0;
    end else begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      arm_q     <= arm_d;
    end
  end

  assign pulse   = deb_q & ~deb_dly_q & arm_q;
  assign prev_p  = pulse[0];
  assign pause_p = pulse[1];
  assign next_p  = pulse[2];

  assign play     = (state_q == S_AUTO) || (state_q == S_STUDY);
  assign auto_run = (state_q == S_AUTO) && !pause_q && song_end;

`ifdef PLAYER_CTRL_AUTONEXT_EN
  assign step_up   = next_p | auto_run;
  assign end_pause = 1'b0;
`else
  assign step_up   = next_p;
  assign end_pause = auto_run;
`endif

  // Next-state for mode FSM, song index, pause flag and output muxes
  always_comb begin
    case (mode)
      3'b011:  state_d = S_AUTO;
      3'b001:  state_d = S_MANUAL;
      3'b111:  state_d = S_STUDY;
      default: state_d = S_IDLE;
    endcase

    song_num_d = song_num_q;
    pause_d    = pause_q;
    if (play) begin
      if (pause_p) pause_d = ~pause_q;
      if (step_up && !prev_p) begin
        song_num_d = (song_num_q == SONG_MAX) ? '0 : song_num_q + 1'b1;
      end else if (prev_p && !step_up) begin
        song_num_d = (song_num_q == '0) ? SONG_MAX : song_num_q - 1'b1;
      end
      if (end_pause) pause_d = 1'b1;
    end
    if ((state_d == S_IDLE) || (state_d == S_MANUAL)) begin
      pause_d = 1'b1;
    end else if (state_d != state_q) begin
      pause_d = 1'b0;
    end

    speaker_d = 1'b0;
    led_d     = '0;
    case (state_q)
      S_AUTO: begin
        speaker_d = speaker_auto & ~pause_q;
        led_d     = led_auto;
      end
      S_MANUAL: speaker_d = speaker_key;
      S_STUDY: begin
        speaker_d = speaker_study | speaker_key;
        led_d     = led_study;
      end
      default: ;
    endcase
  end

  // Mode FSM with registered outputs; song_chg fires the cycle after song_num moves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      song_num_q  <= '0;
      song_last_q <= '0;
      pause_q     <= 1'b1;
      song_chg_q  <= 1'b0;
      speaker_q   <= 1'b0;
      led_q       <= '0;
    end else begin
      state_q     <= state_d;
      song_num_q  <= song_num_d;
      song_last_q <= song_num_q;
      pause_q     <= pause_d;
      song_chg_q  <= (song_num_q != song_last_q);
      speaker_q   <= speaker_d;
      led_q       <= led_d;
    end
  end

  assign song_num = song_num_q;
  assign pause    = pause_q;
  assign song_chg = song_chg_q;
  assign state    = state_q;
  assign speaker  = speaker_q;
  assign led      = led_q;

endmodule

// File: tb/tb_player_ctrl.sv
// tb/tb_player_ctrl.sv - scoreboard testbench for player_ctrl
module tb_player_ctrl;
  localparam int NS  = 4;
  localparam int SW  = 2;
  localparam int DEB = 4;
  localparam int LW  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    button = '0;
  logic [2:0]    mode = '0;
  logic          song_end = 1'b0;
  logic          speaker_auto = 1'b0;
  logic          speaker_key = 1'b0;
  logic          speaker_study = 1'b0;
  logic [LW-1:0] led_auto = '0;
  logic [LW-1:0] led_study = '0;
  logic [SW-1:0] song_num;
  logic          pause;
  logic          song_chg;
  logic [1:0]    state;
  logic          speaker;
  logic [LW-1:0] led;

  int            checks = 0;
  int            errors = 0;
  logic [SW-1:0] exp_q[$];
  int            exp_song = 0;

  player_ctrl #(
    .NUM_SONGS(NS), .SONG_W(SW), .DEB_CYCLES(DEB), .LED_W(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .button(button), .mode(mode), .song_end(song_end),
    .speaker_auto(speaker_auto), .speaker_key(speaker_key), .speaker_study(speaker_study),
    .led_auto(led_auto), .led_study(led_study),
    .song_num(song_num), .pause(pause), .song_chg(song_chg), .state(state),
    .speaker(speaker), .led(led)
  );

  always #5 clk = ~clk;

  // Monitor: every song_chg pulse must match the next expected song index
  always @(negedge clk) begin
    logic [SW-1:0] e;
    if (rst_n && song_chg) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL song_chg_unexpected actual=pulse(song %0d) required=no pulse", song_num);
      end else begin
        e = exp_q.pop_front();
        if (song_num !== e) begin
          errors++;
          $display("FAIL song_chg_value actual=%0d required=%0d", song_num, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [2:0] bits);
    button = bits;
    tick(10);
    button = '0;
    tick(10);
  endtask

  task automatic next_press();
    exp_song = (exp_song + 1) % NS;
    exp_q.push_back(SW'(exp_song));
    press(3'b100);
  endtask

  task automatic prev_press();
    exp_song = (exp_song + NS - 1) % NS;
    exp_q.push_back(SW'(exp_song));
    press(3'b001);
  endtask

  initial begin
    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_song", 32'(song_num), 32'd0);
    chk("rst_pause", 32'(pause), 32'd1);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    chk("idle_state", 32'(state), 32'd0);

    mode = 3'b011;
    tick(2);
    chk("auto_state", 32'(state), 32'd1);
    chk("auto_pause_clr", 32'(pause), 32'd0);

    next_press();
    chk("next_song1", 32'(song_num), 32'd1);
    chk("next_pause0", 32'(pause), 32'd0);
    next_press();
    next_press();
    next_press();
    chk("next_wrap", 32'(song_num), 32'd0);
    prev_press();
    chk("prev_wrap", 32'(song_num), 32'd3);

    button = 3'b100;
    tick(2);
    button = '0;
    tick(10);
    chk("glitch_ignored", 32'(song_num), 32'd3);

    button = 3'b101;
    tick(10);
    button = '0;
    tick(10);
    chk("next_prev_same", 32'(song_num), 32'd3);

    led_auto = 8'hA5;
    speaker_auto = 1'b1;
    tick(2);
    chk("auto_led", 32'(led), 32'hA5);
    chk("auto_speaker", 32'(speaker), 32'd1);

    press(3'b010);
    chk("pause_toggle1", 32'(pause), 32'd1);
    for (int i = 0; i < 4; i++) begin
      speaker_auto = ~speaker_auto;
      tick(1);
      chk("paused_speaker", 32'(speaker), 32'd0);
    end
    press(3'b010);
    chk("pause_toggle0", 32'(pause), 32'd0);
    speaker_auto = 1'b1;
    tick(2);
    chk("unpaused_speaker", 32'(speaker), 32'd1);

`ifdef PLAYER_CTRL_AUTONEXT_EN
    exp_song = 0;
    exp_q.push_back(SW'(0));
`endif
    song_end = 1'b1;
    tick(1);
    song_end = 1'b0;
    tick(5);
`ifdef PLAYER_CTRL_AUTONEXT_EN
    chk("song_end_song", 32'(song_num), 32'd0);
    chk("song_end_pause", 32'(pause), 32'd0);
`else
    chk("song_end_song", 32'(song_num), 32'd3);
    chk("song_end_pause", 32'(pause), 32'd1);
`endif

    mode = 3'b001;
    tick(2);
    chk("manual_state", 32'(state), 32'd2);
    chk("manual_pause", 32'(pause), 32'd1);
    chk("manual_led", 32'(led), 32'd0);
    speaker_key = 1'b1;
    tick(2);
    chk("manual_spk1", 32'(speaker), 32'd1);
    speaker_key = 1'b0;
    tick(2);
    chk("manual_spk0", 32'(speaker), 32'd0);
    press(3'b100);
    chk("manual_next_ignored", 32'(song_num), 32'(exp_song));

    mode = 3'b111;
    led_study = 8'h3C;
    speaker_key = 1'b1;
    tick(2);
    chk("study_state", 32'(state), 32'd3);
    chk("study_pause_clr", 32'(pause), 32'd0);
    tick(1);
    chk("study_led", 32'(led), 32'h3C);
    chk("study_speaker", 32'(speaker), 32'd1);
    next_press();
    next_press();
    chk("study_song", 32'(song_num), 32'(exp_song));

    button = 3'b100;
    tick(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_song", 32'(song_num), 32'd0);
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_pause", 32'(pause), 32'd1);
    chk("async_rst_speaker", 32'(speaker), 32'd0);
    chk("async_rst_led", 32'(led), 32'd0);
    chk("async_rst_chg", 32'(song_chg), 32'd0);
    exp_song = 0;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    chk("held_through_rst", 32'(song_num), 32'd0);
    button = '0;
    tick(10);
    next_press();
    chk("repress_after_rst", 32'(song_num), 32'd1);

    tick(5);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
